// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Covers the FSM state, the latched op kind, the byte width and the default memory window.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_RD,
        OP_WR,
        OP_BAD
    } op_t;

    localparam int unsigned BYTE_W        = 8;
    localparam logic [15:0] DEF_BASE_ADDR = 16'h0200;
    localparam int unsigned DEF_DEPTH     = 512;

    function automatic op_t decode_op(input logic rd, input logic wr);
        if (rd && wr) begin
            return OP_BAD;
        end else if (rd) begin
            return OP_RD;
        end
        return OP_WR;
    endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Word-organised RAM with independent low/high byte write enables.
// Writes on the rising edge; reads are combinational from the same index.
module mem_byte_ram
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned WIDTH = 2 * BYTE_W,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_lo,
    input  logic             we_hi,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [BYTE_W-1:0]       mem_lo [DEPTH];
    logic [WIDTH-BYTE_W-1:0] mem_hi [DEPTH];

    always_ff @(posedge clk) begin
        if (we_lo) begin
            mem_lo[addr] <= wdata[BYTE_W-1:0];
        end
        if (we_hi) begin
            mem_hi[addr] <= wdata[WIDTH-1:BYTE_W];
        end
    end

    assign rdata = {mem_hi[addr], mem_lo[addr]};

endmodule

// File: rtl/mem_data_port.sv
// Data-memory responder on the MAB/MDB bus: latches a request, waits a fixed number
// of cycles, then answers with a one-cycle mem_ready pulse using little-endian byte lanes.
module mem_data_port
    import mem_pkg::*;
#(
    parameter int unsigned SIZE        = 16,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter logic [15:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     MAB,
    input  logic [SIZE-1:0] MDB_in,
    input  logic            MR,
    input  logic            MW,
    input  logic            BW,
    output logic [SIZE-1:0] MDB_out,
    output logic            mem_ready,
    output logic            mem_err
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [16:0] SPAN  = 17'(2 * DEPTH);
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    state_t          state_q;
    op_t             op_q;
    logic [15:0]     addr_q;
    logic            bw_q;
    logic [SIZE-1:0] wdata_q;
    logic [3:0]      wait_cnt_q;

    logic [15:0]     offset;
    logic            in_range;
    logic            lane;
    logic [AW-1:0]   widx;

    logic            we_lo;
    logic            we_hi;
    logic [SIZE-1:0] ram_wdata;
    logic [SIZE-1:0] ram_rdata;
    logic [SIZE-1:0] resp_data;
    logic            resp_err;
    logic [BYTE_W-1:0] sel_byte;

    // BASE_ADDR is word aligned, so offset[0] is the same lane bit as MAB[0].
    assign offset   = addr_q - BASE_ADDR;
    assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign lane     = offset[0];
    assign widx     = offset[AW:1];
    assign sel_byte = lane ? ram_rdata[SIZE-1:BYTE_W] : ram_rdata[BYTE_W-1:0];

    always_comb begin
        we_lo     = 1'b0;
        we_hi     = 1'b0;
        ram_wdata = wdata_q;
        resp_data = '0;
        resp_err  = 1'b0;
        if (bw_q) begin
            ram_wdata = {wdata_q[SIZE-BYTE_W-1:0], wdata_q[BYTE_W-1:0]};
        end
        case (op_q)
            OP_RD: begin
                if (!in_range) begin
                    resp_err = 1'b1;
                end else if (bw_q) begin
                    resp_data = {{(SIZE - BYTE_W){1'b0}}, sel_byte};
                end else begin
                    resp_data = ram_rdata;
                end
            end
            OP_WR: begin
                if (!in_range) begin
                    resp_err = 1'b1;
                end else if (state_q == RESP && rst_n) begin
                    // Reset on the commit edge aborts the write along with the FSM.
                    we_lo = !bw_q || !lane;
                    we_hi = !bw_q || lane;
                end
            end
            default: resp_err = 1'b1;
        endcase
    end

    mem_byte_ram #(
        .DEPTH (DEPTH),
        .WIDTH (SIZE),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we_lo (we_lo),
        .we_hi (we_hi),
        .addr  (widx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_RD;
            addr_q     <= '0;
            bw_q       <= 1'b0;
            wdata_q    <= '0;
            wait_cnt_q <= '0;
            MDB_out    <= '0;
            mem_ready  <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (MR || MW) begin
                        op_q       <= decode_op(MR, MW);
                        addr_q     <= MAB;
                        bw_q       <= BW;
                        wdata_q    <= MDB_in;
                        wait_cnt_q <= WS;
                        state_q    <= (WS == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    mem_ready <= 1'b1;
                    mem_err   <= resp_err;
                    MDB_out   <= resp_data;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
